// File: rtl/sipo_pkg.sv
// sipo_pkg: shared default word width and holding-register state encoding
package sipo_pkg;
  localparam int DEF_WIDTH = 4;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} hold_state_e;
endpackage

// File: rtl/sipo_deserializer_if.sv
// sipo_deserializer_if: serial input, parallel output handshake and status bundle
interface sipo_deserializer_if #(parameter int WIDTH = sipo_pkg::DEF_WIDTH);
  logic             sync;
  logic             sin_valid;
  logic             sin;
  logic             out_ready;
  logic             clr_overrun;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             overrun;
  modport master (output sync, sin_valid, sin, out_ready, clr_overrun,
                  input  out_valid, out_data, busy, overrun);
  modport slave  (input  sync, sin_valid, sin, out_ready, clr_overrun,
                  output out_valid, out_data, busy, overrun);
endinterface

// File: rtl/sipo_hold_reg.sv
// sipo_hold_reg: EMPTY/FULL holding register with sticky overrun on dropped words
module sipo_hold_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  input  logic             clr_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             overrun_o
);
  hold_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ovr_q, ovr_d;
  logic             drain, take;
  always_comb begin
    drain   = (state_q == FULL) && ready_i;
    take    = load_i && ((state_q == EMPTY) || drain);
    state_d = take ? FULL : drain ? EMPTY : state_q;
    data_d  = take ? data_i : data_q;
    ovr_d   = (load_i && !take) || (ovr_q && !clr_i);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end
  assign valid_o   = state_q == FULL;
  assign data_o    = data_q;
  assign overrun_o = ovr_q;
endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: bit counter and shift register feeding a single-word holding register
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  sipo_deserializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0]    cnt_q, cnt_d, cnt_base;
  logic [WIDTH-1:0] sr_q, sr_d, sr_base;
  logic             done;
  // sync restarts framing before the current bit is taken, so that bit becomes bit 0
  always_comb begin
    cnt_base = bus.sync ? '0 : cnt_q;
    sr_base  = bus.sync ? '0 : sr_q;
    done     = bus.sin_valid && (cnt_base == CW'(WIDTH - 1));
    cnt_d    = !bus.sin_valid ? cnt_base : done ? '0 : cnt_base + CW'(1);
    sr_d     = !bus.sin_valid ? sr_base :
               LSB_FIRST ? {bus.sin, sr_base[WIDTH-1:1]} : {sr_base[WIDTH-2:0], bus.sin};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end
  assign bus.busy = cnt_q != '0;
  sipo_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .reset     (reset),
    .load_i    (done),
    .data_i    (sr_d),
    .ready_i   (bus.out_ready),
    .clr_i     (bus.clr_overrun),
    .valid_o   (bus.out_valid),
    .data_o    (bus.out_data),
    .overrun_o (bus.overrun)
  );
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: scoreboard bench for LSB-first and MSB-first instances under shared stimulus
module tb_sipo_deserializer;
  logic clk = 1'b0;
  logic reset;
  logic sync, sin_valid, sin, out_ready, clr_overrun;
  int checks = 0;
  int errors = 0;
  bit bits[$];
  logic [3:0] q0[$];
  logic [3:0] q1[$];
  bit held;
  bit ov;

  sipo_deserializer_if #(.WIDTH(4)) if0 ();
  sipo_deserializer_if #(.WIDTH(4)) if1 ();
  assign if0.sync = sync;
  assign if0.sin_valid = sin_valid;
  assign if0.sin = sin;
  assign if0.out_ready = out_ready;
  assign if0.clr_overrun = clr_overrun;
  assign if1.sync = sync;
  assign if1.sin_valid = sin_valid;
  assign if1.sin = sin;
  assign if1.out_ready = out_ready;
  assign if1.clr_overrun = clr_overrun;

  sipo_deserializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u_lsb (.clk(clk), .reset(reset), .bus(if0.slave));
  sipo_deserializer #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb (.clk(clk), .reset(reset), .bus(if1.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect bits as a list, form a word every fourth bit, single-entry holder
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bits.delete();
      q0.delete();
      q1.delete();
      held = 1'b0;
      ov = 1'b0;
    end else begin
      bit drain, comp, set_ov;
      logic [3:0] w0, w1;
      drain = held && out_ready;
      comp = 1'b0;
      w0 = '0;
      w1 = '0;
      if (sync) bits.delete();
      if (sin_valid) begin
        bits.push_back(sin);
        if (bits.size() == 4) begin
          comp = 1'b1;
          for (int i = 0; i < 4; i++) begin
            w0[i] = bits[i];
            w1[3-i] = bits[i];
          end
          bits.delete();
        end
      end
      set_ov = comp && held && !drain;
      if (comp && (!held || drain)) begin
        q0.push_back(w0);
        q1.push_back(w1);
        held = 1'b1;
      end else if (drain) held = 1'b0;
      ov = set_ov ? 1'b1 : clr_overrun ? 1'b0 : ov;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("valid_lsb", {31'd0, if0.out_valid}, {31'd0, held});
      chk("valid_msb", {31'd0, if1.out_valid}, {31'd0, held});
      chk("busy_lsb", {31'd0, if0.busy}, {31'd0, bits.size() != 0});
      chk("busy_msb", {31'd0, if1.busy}, {31'd0, bits.size() != 0});
      chk("ovr_lsb", {31'd0, if0.overrun}, {31'd0, ov});
      chk("ovr_msb", {31'd0, if1.overrun}, {31'd0, ov});
      if (if0.out_valid) begin
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL data_lsb: got %0h with no expected word queued", if0.out_data);
        end else chk("data_lsb", {28'd0, if0.out_data}, {28'd0, q0[0]});
      end
      if (if1.out_valid) begin
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL data_msb: got %0h with no expected word queued", if1.out_data);
        end else chk("data_msb", {28'd0, if1.out_data}, {28'd0, q1[0]});
      end
      if (held && out_ready && q0.size() != 0) void'(q0.pop_front());
      if (held && out_ready && q1.size() != 0) void'(q1.pop_front());
    end
  end

  task automatic step(input logic sv, input logic s, input logic sy, input logic rdy, input logic clr);
    sin_valid = sv;
    sin = s;
    sync = sy;
    out_ready = rdy;
    clr_overrun = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] w, input int gap, input logic rdy);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, w[i], 1'b0, rdy, 1'b0);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, if0.out_valid | if1.out_valid}, 32'd0);
    chk({tag, "_data"}, {24'd0, if0.out_data, if1.out_data}, 32'd0);
    chk({tag, "_busy"}, {31'd0, if0.busy | if1.busy}, 32'd0);
    chk({tag, "_ovr"}, {31'd0, if0.overrun | if1.overrun}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    sync = 1'b0;
    sin_valid = 1'b0;
    sin = 1'b0;
    out_ready = 1'b0;
    clr_overrun = 1'b0;
    #12;
    chk_zero("por");
    reset = 1'b1;
    @(posedge clk);
    #1;
    send(4'b1101, 0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(4'b1101, 2, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(4'hA, 0, 1'b0);
    send(4'h5, 1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_zero("async_rst");
    reset = 1'b1;
    send(4'b0110, 0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 29) == 0,
           1'($urandom), $urandom_range(0, 19) == 0);
    for (int n = 0; n < 4; n++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("leftover_lsb", q0.size(), 32'd0);
    chk("leftover_msb", q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001: Parameter WIDTH, default 4, SHALL set the number of bits per word (legal range 2..32).
REQ-002: Parameter LSB_FIRST, default 1, SHALL place the first received bit in out_data[0] when 1, and in out_data[WIDTH-1] when 0.
REQ-003: clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004: reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005: sync  input  1  SHALL restart word framing (abort the partial word).
REQ-006: sin_valid  input  1  SHALL mark sin as carrying a valid bit this cycle.
REQ-007: sin  input  1  SHALL carry the serial data bit.
REQ-008: out_ready  input  1  SHALL indicate the consumer accepts out_data this cycle.
REQ-009: clr_overrun  input  1  SHALL clear the sticky overrun flag.
REQ-010: out_valid  output  1  SHALL indicate the holding register contains an unconsumed word.
REQ-011: out_data  output  WIDTH  SHALL carry the held word.
REQ-012: busy  output  1  SHALL be high while a partial word is being assembled (bit count != 0).
REQ-013: overrun  output  1  SHALL be a sticky flag set when a completed word is dropped.

Function
REQ-014: Each cycle with sin_valid=1 SHALL shift sin into the shift register and increment the bit count, modulo WIDTH.
REQ-015: The cycle in which the WIDTH-th bit is accepted SHALL complete the word and wrap the bit count to 0.
REQ-016: A completed word SHALL be transferred to the holding register on that same edge, giving out_valid=1 one cycle after the final bit is sampled.
REQ-017: Holding-register FSM states SHALL be EMPTY and FULL. Transitions: EMPTY->FULL on word complete; FULL->EMPTY on out_valid&out_ready with no completion; FULL stays FULL on simultaneous drain and completion, with the new word loaded.
REQ-018: A completion while FULL and not draining SHALL discard the new word, keep the held word unchanged, and set overrun.
REQ-019: out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020: sync=1 SHALL zero the bit count and shift register; sync with sin_valid in the same cycle SHALL accept sin as bit 0 of a new word.
REQ-021: sync SHALL NOT affect the holding register, out_valid, or overrun.
REQ-022: clr_overrun SHALL clear overrun; a simultaneous set condition SHALL take priority, leaving overrun=1.
REQ-023: Cycles with sin_valid=0 SHALL hold all shift state; gaps between bits SHALL be permitted.

Reset
REQ-024: reset low SHALL immediately force the following, independent of clk: bit count=0, shift register=0, holding register=0, FSM=EMPTY, out_valid=0, busy=0, overrun=0.
REQ-025: Reset asserted mid-word SHALL discard the partial word; the first valid bit after release SHALL be bit 0.
REQ-026: Reset release SHALL take effect at the first rising clk edge after reset goes high.

Structure
REQ-027: The default WIDTH and the EMPTY/FULL state encoding SHALL live in shared package sipo_pkg.
REQ-028: The holding register and its FSM SHALL be one sub-module, sipo_hold_reg; bit counter and shift register SHALL reside in sipo_deserializer.

Verification (WIDTH=4)
REQ-029: LSB_FIRST=1, bits 1,0,1,1 on consecutive cycles, out_ready=1 -> out_valid pulses one cycle later with out_data=4'b1101.
REQ-030: LSB_FIRST=0, same bits with 2 idle cycles between bits -> out_data=4'b1011; busy high from the first bit until the fourth.
REQ-031: out_ready=0, two full words 4'hA then 4'h5 -> out_data stays 4'hA, overrun=1; assert clr_overrun -> overrun=0.
REQ-032: out_ready=1 in the same cycle the next word completes -> FSM stays FULL and out_data updates to the new word with no overrun.
REQ-033: Two bits sent, then sync with sin_valid=1, sin=1, followed by 0,0,0 -> out_data=4'b0001; the earlier out_valid state is unaffected.
REQ-034: reset pulsed low between clock edges after 3 bits -> all outputs are 0 immediately; the next 4 bits form a complete word.
